// File: rtl/ct_pkg.sv
// Shared types and helpers for the ct_* merge blocks: arbiter state encoding and clog2.
package ct_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ct_skid2.sv
// Two-entry output buffer: ready comes straight from a flop, one cycle of latency,
// full throughput, head entry held stable while the consumer stalls.
module ct_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             not_full_q, not_full_d;
  logic             push;
  logic             pop;

  assign push = i_valid & not_full_q;
  assign pop  = (count_q != 2'd0) & i_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Retire the head first so a same-cycle push lands in the freed slot.
    if (pop) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        head_d = i_data;
      end else begin
        tail_d = i_data;
      end
      count_d = count_d + 2'd1;
    end
    not_full_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  assign o_ready = not_full_q;
  assign o_valid = (count_q != 2'd0);
  assign o_data  = head_q;

endmodule

// File: rtl/ct_merge_ex.sv
// Round-robin merge of RADIX valid/ready channels with optional packet locking.
// Define CT_MERGE_EX_OUT_REG_EN to register the merged output through ct_skid2.
module ct_merge_ex
  import ct_pkg::*;
#(
  parameter int RADIX    = 2,
  parameter int WIDTH    = 8,
  parameter int EOP      = 0,
  parameter int PKT_MODE = 1,
  localparam int SRCBITS = (clog2(RADIX) > 1) ? clog2(RADIX) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RADIX*WIDTH-1:0]   i_data,
  input  logic [RADIX-1:0]         i_valid,
  output logic [RADIX-1:0]         o_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [SRCBITS-1:0]       o_src,
  input  logic                     i_ready
);

  state_t             state_q, state_d;
  logic [SRCBITS-1:0] last_q, last_d;
  logic [SRCBITS-1:0] sel;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_valid;
  logic               int_ready;
  logic               in_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= SRCBITS'(RADIX - 1);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Rotating priority starts just after the last served channel, which is searched last.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    sel   = last_q;
    if (state_q == S_IDLE) begin
      for (int i = 1; i <= RADIX; i++) begin
        idx = (int'(last_q) + i) % RADIX;
        if (!found && i_valid[idx]) begin
          sel   = SRCBITS'(idx);
          found = 1'b1;
        end
      end
    end
    if (RADIX == 1) begin
      sel = '0;
    end
    sel_data  = i_data[int'(sel)*WIDTH +: WIDTH];
    sel_valid = i_valid[sel];
  end

  assign in_fire = sel_valid & int_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (in_fire) begin
      last_d = sel;
      if (PKT_MODE != 0) begin
        case (state_q)
          S_IDLE:  if (!sel_data[EOP]) state_d = S_LOCK;
          S_LOCK:  if (sel_data[EOP])  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < RADIX; gi++) begin : g_ready
      assign o_ready[gi] = int_ready & ~reset & (sel == SRCBITS'(gi));
    end
  endgenerate

`ifdef CT_MERGE_EX_OUT_REG_EN
  logic [SRCBITS+WIDTH-1:0] skid_out;

  ct_skid2 #(
    .WIDTH(SRCBITS + WIDTH)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_data ({sel, sel_data}),
    .i_valid(sel_valid),
    .o_ready(int_ready),
    .o_data (skid_out),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  assign o_data = skid_out[WIDTH-1:0];
  assign o_src  = skid_out[WIDTH +: SRCBITS];
`else
  assign int_ready = i_ready;
  assign o_valid   = sel_valid & ~reset;
  assign o_data    = sel_data;
  assign o_src     = sel;
`endif

endmodule
